// File: rtl/stopwatch_counter.sv
// -----------------------------------------------------------------------------
// stopwatch_counter
//
// Four-digit BCD stopwatch (SS.hh, 00.00 .. 99.99) run by the game FSM.
// A prescaler divides the system clock down to hundredths of a second. Each
// prescaler tick advances a ripple-carry BCD count by one hundredth.
//
// Ports
//   clk_i       in   1   system clock
//   res_i       in   1   synchronous active-high reset (highest priority)
//   game_res_i  in   1   in-game clear from the FSM; same effect as res_i
//   pause_i     in   1   freeze counting (prescaler and digits hold)
//   digits_o    out  16  {sec_tens, sec_ones, cs_tens, cs_ones}, BCD
//   win_o       out  1   whole, non-zero second is shown (decode of digits)
//   wrap_o      out  1   sticky: count rolled 99.99 -> 00.00 since last clear
//
// Parameter
//   TICKS_PER_CS  clock cycles per hundredth of a second (>= 1)
// -----------------------------------------------------------------------------
module stopwatch_counter #(
    parameter int unsigned TICKS_PER_CS = 500_000
) (
    input  logic        clk_i,
    input  logic        res_i,
    input  logic        game_res_i,
    input  logic        pause_i,
    output logic [15:0] digits_o,
    output logic        win_o,
    output logic        wrap_o
);

    // A one-cycle prescaler still needs one bit so the register is legal.
    localparam int unsigned PRESC_W = (TICKS_PER_CS > 32'd1) ? $clog2(TICKS_PER_CS) : 32'd1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_CS - 32'd1);

    // One BCD digit step: returns {carry_out, next_digit}. Any value at or
    // above 9 rolls to 0 so an upset digit can never stick outside 0..9.
    function automatic logic [4:0] bcd_digit_inc(input logic [3:0] digit, input logic carry_in);
        logic [4:0] result;
        if (!carry_in) begin
            result = {1'b0, digit};
        end else if (digit >= 4'd9) begin
            result = {1'b1, 4'd0};
        end else begin
            result = {1'b0, digit + 4'd1};
        end
        return result;
    endfunction

    // Whole-count increment by one hundredth: returns {wrap_carry, next_value}.
    function automatic logic [16:0] bcd_count_inc(input logic [15:0] value);
        logic [4:0] cs_ones;
        logic [4:0] cs_tens;
        logic [4:0] sec_ones;
        logic [4:0] sec_tens;
        cs_ones  = bcd_digit_inc(value[3:0],   1'b1);
        cs_tens  = bcd_digit_inc(value[7:4],   cs_ones[4]);
        sec_ones = bcd_digit_inc(value[11:8],  cs_tens[4]);
        sec_tens = bcd_digit_inc(value[15:12], sec_ones[4]);
        return {sec_tens[4], sec_tens[3:0], sec_ones[3:0], cs_tens[3:0], cs_ones[3:0]};
    endfunction

    logic [15:0]        digits_r;
    logic [PRESC_W-1:0] presc_r;
    logic               wrap_r;
    logic               tick_s;
    logic [16:0]        inc_s;
    logic               win_s;

    // Tick qualification, next BCD value and the win decode of the digit registers.
    always_comb begin
        tick_s = 1'b0;
        inc_s  = 17'd0;
        win_s  = 1'b0;
        if ((presc_r == PRESC_LAST) && !pause_i) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
        inc_s = bcd_count_inc(digits_r);
        // A whole second with zero hundredths; 00.00 (also after a wrap) is never a win.
        if ((digits_r[7:0] == 8'h00) && (digits_r[15:8] != 8'h00)) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    // Prescaler, BCD count and sticky wrap flag; clears beat pause, pause beats counting.
    always_ff @(posedge clk_i) begin
        if (res_i) begin
            digits_r <= 16'h0000;
            presc_r  <= '0;
            wrap_r   <= 1'b0;
        end else if (game_res_i) begin
            digits_r <= 16'h0000;
            presc_r  <= '0;
            wrap_r   <= 1'b0;
        end else if (tick_s) begin
            presc_r  <= '0;
            digits_r <= inc_s[15:0];
            if (inc_s[16]) begin
                wrap_r <= 1'b1;
            end else begin
                wrap_r <= wrap_r;
            end
        end else if (!pause_i) begin
            presc_r  <= presc_r + PRESC_W'(1);
            digits_r <= digits_r;
            wrap_r   <= wrap_r;
        end else begin
            // Paused: keep the partial hundredth so counting resumes where it left off.
            presc_r  <= presc_r;
            digits_r <= digits_r;
            wrap_r   <= wrap_r;
        end
    end

    assign digits_o = digits_r;
    assign win_o    = win_s;
    assign wrap_o   = wrap_r;

endmodule

// File: tb/tb_stopwatch_counter.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_counter
//
// Two instances: u_fast (TICKS_PER_CS = 1) and u_slow (TICKS_PER_CS = 3).
// The stimulus process pushes hand-computed expectations, tagged with the
// clock cycle at which they apply, into a queue. A separate monitor samples
// both instances on the falling edge and checks every entry due that cycle.
// -----------------------------------------------------------------------------
module tb_stopwatch_counter;

    logic        clk;
    logic        res_f, game_res_f, pause_f;
    logic        res_s, game_res_s, pause_s;
    logic [15:0] digits_f, digits_s;
    logic        win_f, win_s, wrap_f, wrap_s;

    int cyc;
    int n_total;
    int n_pass;

    typedef struct {
        int          cyc;
        int          sel;      // 0 = u_fast, 1 = u_slow
        logic [15:0] digits;
        logic        win;
        logic        wrap;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    stopwatch_counter #(.TICKS_PER_CS(1)) u_fast (
        .clk_i      (clk),
        .res_i      (res_f),
        .game_res_i (game_res_f),
        .pause_i    (pause_f),
        .digits_o   (digits_f),
        .win_o      (win_f),
        .wrap_o     (wrap_f)
    );

    stopwatch_counter #(.TICKS_PER_CS(3)) u_slow (
        .clk_i      (clk),
        .res_i      (res_s),
        .game_res_i (game_res_s),
        .pause_i    (pause_s),
        .digits_o   (digits_s),
        .win_o      (win_s),
        .wrap_o     (wrap_s)
    );

    // Clock: rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index = number of rising edges seen.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Advance n rising edges, then settle past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input int sel, input string name,
                              input logic [15:0] digits, input logic win, input logic wrap);
        exp_t e;
        e.cyc    = cyc;
        e.sel    = sel;
        e.digits = digits;
        e.win    = win;
        e.wrap   = wrap;
        e.name   = name;
        exp_q.push_back(e);
    endtask

    // Monitor: check every expectation due this cycle away from the rising edge.
    initial begin
        n_total = 0;
        n_pass  = 0;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                exp_t e;
                logic [15:0] a_digits;
                logic        a_win, a_wrap;
                e = exp_q.pop_front();
                a_digits = (e.sel == 0) ? digits_f : digits_s;
                a_win    = (e.sel == 0) ? win_f    : win_s;
                a_wrap   = (e.sel == 0) ? wrap_f   : wrap_s;
                n_total++;
                if (e.cyc != cyc) begin
                    $display("FAIL %s: sampled late at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
                end else if (a_digits !== e.digits || a_win !== e.win || a_wrap !== e.wrap) begin
                    $display("FAIL %s: got digits=%h win=%b wrap=%b, required digits=%h win=%b wrap=%b",
                             e.name, a_digits, a_win, a_wrap, e.digits, e.win, e.wrap);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        res_f = 1'b1; game_res_f = 1'b0; pause_f = 1'b0;
        res_s = 1'b1; game_res_s = 1'b0; pause_s = 1'b0;
        step(2);
        expect_out(0, "reset_fast", 16'h0000, 1'b0, 1'b0);
        expect_out(1, "reset_slow", 16'h0000, 1'b0, 1'b0);

        // ---- TICKS_PER_CS = 3: first change 3 cycles after reset falls ----
        res_s = 1'b0;
        step(2);
        expect_out(1, "slow_before_first_tick", 16'h0000, 1'b0, 1'b0);
        step(1);
        expect_out(1, "slow_first_tick", 16'h0001, 1'b0, 1'b0);

        // Pause at prescaler = 1 for 10 cycles, then next increment 2 cycles later.
        step(1);
        pause_s = 1'b1;
        step(10);
        expect_out(1, "slow_pause_hold", 16'h0001, 1'b0, 1'b0);
        pause_s = 1'b0;
        step(1);
        expect_out(1, "slow_resume_1", 16'h0001, 1'b0, 1'b0);
        step(1);
        expect_out(1, "slow_resume_2", 16'h0002, 1'b0, 1'b0);

        // Reset mid-count clears on that edge.
        step(1);
        res_s = 1'b1;
        step(1);
        expect_out(1, "slow_res_mid", 16'h0000, 1'b0, 1'b0);
        res_s = 1'b0;

        // Pause exactly at terminal count: no tick, prescaler holds at 2.
        step(2);
        pause_s = 1'b1;
        step(3);
        expect_out(1, "slow_pause_at_tc", 16'h0000, 1'b0, 1'b0);
        pause_s = 1'b0;
        step(1);
        expect_out(1, "slow_tick_after_tc", 16'h0001, 1'b0, 1'b0);

        // ---- TICKS_PER_CS = 1: carry chain, win decode, wrap, clears ----
        res_f = 1'b0;
        step(99);
        expect_out(0, "fast_0099", 16'h0099, 1'b0, 1'b0);
        step(1);
        expect_out(0, "fast_0100_win", 16'h0100, 1'b1, 1'b0);
        step(1);
        expect_out(0, "fast_0101", 16'h0101, 1'b0, 1'b0);
        step(99);
        expect_out(0, "fast_0200_win", 16'h0200, 1'b1, 1'b0);
        step(1);
        expect_out(0, "fast_0201", 16'h0201, 1'b0, 1'b0);
        step(799);
        expect_out(0, "fast_1000_win", 16'h1000, 1'b1, 1'b0);
        step(8999);
        expect_out(0, "fast_9999", 16'h9999, 1'b0, 1'b0);
        step(1);
        expect_out(0, "fast_wrap_0000", 16'h0000, 1'b0, 1'b1);
        step(1);
        expect_out(0, "fast_wrap_sticky", 16'h0001, 1'b0, 1'b1);
        pause_f = 1'b1;
        step(5);
        expect_out(0, "fast_pause_hold", 16'h0001, 1'b0, 1'b1);
        pause_f = 1'b0;
        step(41);
        expect_out(0, "fast_0042", 16'h0042, 1'b0, 1'b1);

        // Clear beats tick in the same cycle.
        game_res_f = 1'b1;
        step(1);
        expect_out(0, "fast_clear_vs_tick", 16'h0000, 1'b0, 1'b0);
        game_res_f = 1'b0;
        step(5);
        expect_out(0, "fast_after_clear", 16'h0005, 1'b0, 1'b0);

        // Clear applies even while paused.
        pause_f = 1'b1;
        game_res_f = 1'b1;
        step(1);
        expect_out(0, "fast_clear_while_paused", 16'h0000, 1'b0, 1'b0);
        game_res_f = 1'b0;
        pause_f = 1'b0;
        step(1);
        expect_out(0, "fast_count_after_clear", 16'h0001, 1'b0, 1'b0);

        // Let the monitor drain, then make sure nothing was left unchecked.
        step(3);
        n_total++;
        if (exp_q.size() != 0) begin
            $display("FAIL queue_drain: %0d entries left, required 0", exp_q.size());
        end else begin
            n_pass++;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

Four-digit BCD stopwatch (SS.hh, 00.00–99.99) driven by the game FSM's in-game reset and pause outputs. It produces the "win" qualifier the FSM samples while in its shoot state. It also supplies the digit vector the display path shows for the stopwatch message. It sits directly downstream of the game FSM (consumes `reset_o`/`pause_o`) and upstream of it (feeds `win_i`).

## Interface
- `TICKS_PER_CS`, default 500_000: clock cycles per hundredth of a second (50 MHz clock); legal range ≥ 1.
- `clk_i`  in  1  system clock.
- `res_i`  in  1  synchronous, active-high reset.
- `game_res_i`  in  1  in-game counter clear, from FSM `reset_o`; synchronous, active-high.
- `pause_i`  in  1  freeze counting when 1, from FSM `pause_o`.
- `digits_o`  out  16  BCD digits {sec_tens, sec_ones, cs_tens, cs_ones}, 4 bits each.
- `win_o`  out  1  to FSM `win_i`; 1 when stopwatch shows a whole, non-zero second.
- `wrap_o`  out  1  sticky: counter has wrapped 99.99→00.00 since last clear.

## Operation
- Clock and reset: one clock; reset is synchronous and active-high. Reset values: `digits_o` = 16'h0000, prescaler = 0, `wrap_o` = 0, `win_o` = 0.
- Priority per cycle: `res_i` > `game_res_i` > `pause_i` > count.
- `game_res_i` = 1 has the same effect as `res_i`: digits, prescaler and `wrap_o` cleared. It applies regardless of `pause_i`.
- Prescaler: unsigned counter of width max(1, $clog2(TICKS_PER_CS)).
  - Counts 0…TICKS_PER_CS−1 while `pause_i` = 0.
  - Holds its value while `pause_i` = 1. It is not cleared, so the partial hundredth is kept across a pause.
- Tick: prescaler == TICKS_PER_CS−1 and `pause_i` = 0. On a tick the prescaler returns to 0 and the BCD value increments by one hundredth.
  - With TICKS_PER_CS = 1, every unpaused cycle is a tick.
- BCD increment is a ripple carry cs_ones → cs_tens → sec_ones → sec_tens. Each digit steps 0…9, then returns to 0 with a carry. Digit values 10–15 never occur.
- Wrap: a tick at 99.99 gives 00.00 and sets `wrap_o` = 1. `wrap_o` stays 1 until `res_i` or `game_res_i`.
- `win_o` = (cs_tens == 0) && (cs_ones == 0) && ({sec_tens, sec_ones} != 0).
  - It is a combinational decode of the digit registers, so there are no extra flops.
  - 00.00 is never a win, including the value after a wrap.

## Timing
- Counting latency: the first tick after `pause_i` falls at prescaler p arrives TICKS_PER_CS−p cycles later. `digits_o` changes on the clock edge of the tick cycle.
- Pause latency:
  - `pause_i` = 1 sampled at edge N means no digit change at edge N.
  - The value is frozen from that edge on. The FSM's shoot state therefore sees a stable `digits_o`/`win_o` throughout its pause window.
- `win_o` is valid in the same cycle as the `digits_o` value it decodes (0 added latency).
- Clear latency: `game_res_i` sampled at edge N gives `digits_o` = 0, `win_o` = 0, `wrap_o` = 0 after edge N.
- Simultaneous cases:
  - `game_res_i` = 1 and a tick in the same cycle: the clear wins, and the result is 0.
  - `pause_i` = 1 and prescaler at terminal count: no tick, and the prescaler holds at TICKS_PER_CS−1.
  - `res_i` asserted mid-count: everything is cleared on that edge.

## Test plan
- Reset: hold `res_i` 1 cycle with `pause_i` = 0 → `digits_o` = 16'h0000, `win_o` = 0, `wrap_o` = 0. With TICKS_PER_CS = 3, the first change is to 16'h0001, 3 cycles after `res_i` falls.
- Carry chain: TICKS_PER_CS = 1, run 99 cycles from 0 → 16'h0099 with `win_o` = 0. Next cycle → 16'h0100 with `win_o` = 1. Next cycle → 16'h0101 with `win_o` = 0.
- Pause hold: TICKS_PER_CS = 3, pause when prescaler = 1 and hold for 10 cycles → digits and prescaler unchanged. After release, the next increment comes 2 cycles later.
- Wrap: TICKS_PER_CS = 1, run 9999 cycles → 16'h9999 with `wrap_o` = 0. Next cycle → 16'h0000 with `wrap_o` = 1 and `win_o` = 0. `wrap_o` stays 1 until `game_res_i`.
- Clear vs tick: TICKS_PER_CS = 1 at 16'h0042, assert `game_res_i` with `pause_i` = 0 → 16'h0000 on that edge, not 16'h0043.
- FSM co-sim with `fsm_game`, PAUSE_DURATINON_HW_TICKS = 5 and TICKS_PER_CS = 1:
  - Strobe the button so that the shoot state captures 16'h0200 → `win_i` = 1 and the FSM reaches WIN_S.
  - Capturing 16'h0201 instead → the FSM returns to RUN_S.
